loader_sb_multi: RTL and testbench
==================================

# loader_sb_multi

Parametrised configuration-strobe loader for switch-box tiles with any number of configuration-memory channels (up, down-L1, down-L2, down-out, …), each with its own width. It decodes ADDRESS into a channel and a word index, then drives one-hot write strobes into that channel's configuration memory. Each strobe is held for a programmable number of cycles. One request can issue a burst of consecutive strobes. The block reports completion and errors through a READY/DONE/ERROR handshake.

## Interface
- ADDRESS_SIZE, 9, address width; top CH_SEL_BITS select the channel, the rest are the word index.
- NB_CHANNELS, 4, number of strobe channels.
- STROBE_MAX, 84, per-channel slot width in the flat STROBE bus.
- CH_WIDTHS, {8'd8,8'd84,8'd32,8'd32}, packed 8-bit per-channel strobe widths, channel 0 in the LSBs; each value is ≤ STROBE_MAX.
- PULSE_LEN, 1, strobe high time in cycles; must be ≥ 1.
- BURST_BITS, 8, width of BURST_LEN.
- CH_SEL_BITS (localparam), $clog2(NB_CHANNELS).
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-low reset; clock CLK.
- SELECT  in  1  request valid; sampled only when READY=1.
- ADDRESS  in  ADDRESS_SIZE  {channel, start index}.
- BURST_LEN  in  BURST_BITS  extra strobes after the first (0 = single).
- READY  out  1  block idle and accepting a request.
- DONE  out  1  one-cycle pulse after the last strobe of a request.
- ERROR  out  1  one-cycle pulse for a rejected request.
- STROBE  out  NB_CHANNELS*STROBE_MAX  flat one-hot strobe bus; channel c occupies bits [c*STROBE_MAX +: STROBE_MAX].
- ACTIVE_CH  out  NB_CHANNELS  one-hot flag for the channel currently being strobed.

## Operation
- **States:** IDLE, PULSE, GAP, FIN.
- **IDLE.** When SELECT=1 and READY=1, capture the request:
  - ch = ADDRESS[ADDRESS_SIZE-1 -: CH_SEL_BITS]
  - idx = low bits of ADDRESS
  - rem = BURST_LEN
- **Validity check:** ch < NB_CHANNELS and idx+BURST_LEN < CH_WIDTHS[ch]. Compute the sum in max(ADDRESS_SIZE,BURST_BITS)+1 bits so it cannot overflow.
  - Invalid: pulse ERROR, stay in IDLE, no strobe is driven.
  - Valid: go to PULSE.
- **PULSE:**
  - STROBE bit ch*STROBE_MAX+idx = 1; all other bits 0; ACTIVE_CH[ch] = 1.
  - Hold for PULSE_LEN cycles using an internal counter.
  - Then: if rem=0 go to FIN; otherwise go to GAP with idx+1 and rem-1.
- **GAP:** STROBE=0 and ACTIVE_CH=0 for one cycle, then back to PULSE.
- **FIN:** DONE=1 for one cycle, then IDLE.
- STROBE bits at positions ≥ CH_WIDTHS[c] within a slot are never asserted.
- Non-power-of-two NB_CHANNELS: a channel code ≥ NB_CHANNELS is an error.
- READY = (state==IDLE) && RESET==1.
- SELECT is ignored while READY=0; no queuing.
- STROBE, ACTIVE_CH, DONE and ERROR are all registered.

## Timing
- **Reset:** while RESET=0 on a rising edge:
  - state goes to IDLE and all counters clear;
  - STROBE=0, ACTIVE_CH=0, DONE=0, ERROR=0;
  - READY=0, and READY goes to 1 in the first cycle after RESET returns to 1.
- **Request accepted at edge k:**
  - strobe n (n = 0..BURST_LEN) is high during cycles k+1+n*(PULSE_LEN+1) through k+PULSE_LEN+n*(PULSE_LEN+1);
  - DONE is high in the cycle right after the last strobe cycle;
  - READY returns in the cycle after DONE.
- **Error:** ERROR is high during cycle k+1; READY stays 1 throughout, so a new request can be accepted at edge k+1.
- **Reset mid-operation:** the next edge clears all strobes immediately and aborts the request; no DONE is produced.
- **SELECT with RESET=0:** ignored.

## Test plan
- **Reset:** hold RESET=0 for 3 cycles → STROBE=0, ACTIVE_CH=0, DONE=0, ERROR=0, READY=0; READY=1 in the first cycle after release.
- **Single strobe:** ADDRESS={2'd2,7'd83}, BURST_LEN=0, SELECT for 1 cycle at edge k → STROBE[251] high only during k+1, ACTIVE_CH=4'b0100, DONE at k+2, READY at k+3.
- **Burst:** ADDRESS={2'd3,7'd4}, BURST_LEN=3 → STROBE bits 256, 257, 258, 259 each high for one cycle at k+1, k+3, k+5, k+7; STROBE=0 at k+2, k+4, k+6; DONE at k+8.
- **Range errors:**
  - ADDRESS={2'd3,7'd6}, BURST_LEN=2 → ERROR at k+1, no strobe, READY stays 1.
  - ADDRESS={2'd0,7'd32}, BURST_LEN=0 → ERROR at k+1.
- **Reset mid-burst:** ADDRESS={2'd0,7'd0}, BURST_LEN=10, RESET=0 at edge k+4 → STROBE=0 from k+5 and no DONE. After release, a single request to ADDRESS={2'd1,7'd0} → STROBE[84] pulses.
- **SELECT while busy:** during a burst, assert SELECT with ADDRESS={2'd1,7'd5} → STROBE[89] never asserted; the original burst completes unchanged.

Source files
------------

// File: rtl/loader_sb_multi.sv
// Configuration-strobe loader for switch-box tiles: decodes {channel, word index}
// and issues held, optionally bursted, one-hot write strobes into that channel.
module loader_sb_multi #(
    parameter int                         ADDRESS_SIZE = 9,
    parameter int                         NB_CHANNELS  = 4,
    parameter int                         STROBE_MAX   = 84,
    parameter logic [NB_CHANNELS*8-1:0]   CH_WIDTHS    = {8'd8, 8'd84, 8'd32, 8'd32},
    parameter int                         PULSE_LEN    = 1,
    parameter int                         BURST_BITS   = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              SELECT,
    input  logic [ADDRESS_SIZE-1:0]           ADDRESS,
    input  logic [BURST_BITS-1:0]             BURST_LEN,
    output logic                              READY,
    output logic                              DONE,
    output logic                              ERROR,
    output logic [NB_CHANNELS*STROBE_MAX-1:0] STROBE,
    output logic [NB_CHANNELS-1:0]            ACTIVE_CH
);

    localparam int CH_SEL_BITS = $clog2(NB_CHANNELS);
    localparam int IDX_BITS    = ADDRESS_SIZE - CH_SEL_BITS;
    // Wide enough that start index plus burst length can never wrap.
    localparam int SUM_W       = ((ADDRESS_SIZE > BURST_BITS) ? ADDRESS_SIZE : BURST_BITS) + 1;
    localparam int CNT_W       = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, FIN} state_t;

    state_t                          state_q, state_d;
    logic [CH_SEL_BITS-1:0]          ch_q, ch_d;
    logic [SUM_W-1:0]                idx_q, idx_d;
    logic [BURST_BITS-1:0]           rem_q, rem_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            error_d, done_d;
    logic [NB_CHANNELS*STROBE_MAX-1:0] strobe_d;
    logic [NB_CHANNELS-1:0]          active_d;

    logic [CH_SEL_BITS-1:0]          req_ch;
    logic [IDX_BITS-1:0]             req_idx;
    logic [SUM_W-1:0]                req_end;
    logic                            req_valid;

    // Channel codes beyond NB_CHANNELS report width 0, so every index is out of range.
    function automatic logic [7:0] ch_width(input logic [CH_SEL_BITS-1:0] ch);
        if (int'(ch) < NB_CHANNELS)
            return CH_WIDTHS[int'(ch)*8 +: 8];
        else
            return 8'd0;
    endfunction

    assign req_ch    = ADDRESS[ADDRESS_SIZE-1 -: CH_SEL_BITS];
    assign req_idx   = ADDRESS[IDX_BITS-1:0];
    assign req_end   = SUM_W'(req_idx) + SUM_W'(BURST_LEN);
    assign req_valid = (int'(req_ch) < NB_CHANNELS) && (int'(req_end) < int'(ch_width(req_ch)));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (SELECT) begin
                    if (req_valid) begin
                        state_d = PULSE;
                        ch_d    = req_ch;
                        idx_d   = SUM_W'(req_idx);
                        rem_d   = BURST_LEN;
                        cnt_d   = CNT_LAST;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (rem_q == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = GAP;
                        idx_d   = idx_q + SUM_W'(1);
                        rem_d   = rem_q - BURST_BITS'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                state_d = PULSE;
                cnt_d   = CNT_LAST;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the registered strobe lines
    // up with the state it belongs to, with no extra cycle of latency.
    always_comb begin
        strobe_d = '0;
        active_d = '0;
        done_d   = (state_d == FIN);
        if (state_d == PULSE && int'(idx_d) < int'(ch_width(ch_d))) begin
            strobe_d[int'(ch_d)*STROBE_MAX + int'(idx_d)] = 1'b1;
            active_d[ch_d]                                 = 1'b1;
        end
    end

    // NOTE: reset is synchronous here, so it only appears inside the clocked branch,
    // not in the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            STROBE    <= '0;
            ACTIVE_CH <= '0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            STROBE    <= strobe_d;
            ACTIVE_CH <= active_d;
            DONE      <= done_d;
            ERROR     <= error_d;
        end
    end

    assign READY = (state_q == IDLE) && RESET;

endmodule

// File: tb/tb_loader_sb_multi.sv
// Directed bench for loader_sb_multi with default parameters; expected strobe
// positions are hand-computed from {channel, index} and the channel widths.
module tb_loader_sb_multi;

    localparam int SW = 4 * 84;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          SELECT;
    logic [8:0]    ADDRESS;
    logic [7:0]    BURST_LEN;
    logic          READY, DONE, ERROR;
    logic [SW-1:0] STROBE;
    logic [3:0]    ACTIVE_CH;

    int checks   = 0;
    int failures = 0;

    loader_sb_multi dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SELECT    (SELECT),
        .ADDRESS   (ADDRESS),
        .BURST_LEN (BURST_LEN),
        .READY     (READY),
        .DONE      (DONE),
        .ERROR     (ERROR),
        .STROBE    (STROBE),
        .ACTIVE_CH (ACTIVE_CH)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] oh(input int b);
        logic [SW-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents a request for one edge; on return the bench sits in cycle k+1.
    task automatic req(input logic [1:0] ch, input logic [6:0] idx, input logic [7:0] bl);
        ADDRESS   = {ch, idx};
        BURST_LEN = bl;
        SELECT    = 1'b1;
        tick();
        SELECT    = 1'b0;
    endtask

    task automatic single(input string tag, input logic [1:0] ch, input logic [6:0] idx,
                          input int bit_pos, input logic [3:0] act);
        req(ch, idx, 8'd0);
        chk({tag, "_strobe"}, STROBE, oh(bit_pos));
        chk({tag, "_active"}, ACTIVE_CH, act);
        chk({tag, "_ready_busy"}, READY, 1'b0);
        tick();
        chk({tag, "_strobe_off"}, STROBE, '0);
        chk({tag, "_done"}, DONE, 1'b1);
        tick();
        chk({tag, "_done_off"}, DONE, 1'b0);
        chk({tag, "_ready"}, READY, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset, with a valid-looking request presented that must be ignored.
        RESET     = 1'b0;
        SELECT    = 1'b1;
        ADDRESS   = {2'd2, 7'd0};
        BURST_LEN = 8'd0;
        repeat (3) tick();
        chk("rst_strobe", STROBE, '0);
        chk("rst_active", ACTIVE_CH, 4'b0000);
        chk("rst_done", DONE, 1'b0);
        chk("rst_error", ERROR, 1'b0);
        chk("rst_ready", READY, 1'b0);
        SELECT = 1'b0;
        RESET  = 1'b1;
        #1;
        chk("rst_release_ready", READY, 1'b1);
        tick();
        chk("rst_sel_ignored", STROBE, '0);

        // Single strobe at the top of channel 2: bit 2*84+83.
        single("single", 2'd2, 7'd83, 251, 4'b0100);

        // Last legal index of channel 3 (width 8): bit 3*84+7.
        single("edge_ch3", 2'd3, 7'd7, 259, 4'b1000);

        // Burst of 4 from channel 3 index 4, with a competing SELECT held while busy.
        req(2'd3, 7'd4, 8'd3);
        ADDRESS   = {2'd1, 7'd5};
        BURST_LEN = 8'd0;
        SELECT    = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("burst_strobe%0d", n), STROBE, oh(256 + n));
            chk($sformatf("burst_active%0d", n), ACTIVE_CH, 4'b1000);
            if (n == 3) SELECT = 1'b0;
            tick();
            chk($sformatf("burst_gap%0d", n), STROBE, '0);
            chk($sformatf("burst_done%0d", n), DONE, (n == 3) ? 1'b1 : 1'b0);
            if (n < 3) tick();
        end
        tick();
        chk("burst_ready", READY, 1'b1);
        chk("busy_sel_no_strobe", STROBE, '0);
        tick();
        chk("busy_sel_not_queued", STROBE, '0);

        // Range errors, the second one presented back-to-back at edge k+1.
        req(2'd3, 7'd6, 8'd2);
        chk("err1_error", ERROR, 1'b1);
        chk("err1_ready", READY, 1'b1);
        chk("err1_strobe", STROBE, '0);
        req(2'd0, 7'd32, 8'd0);
        chk("err2_error", ERROR, 1'b1);
        chk("err2_strobe", STROBE, '0);
        chk("err2_ready", READY, 1'b1);
        tick();
        chk("err2_error_off", ERROR, 1'b0);

        // Reset mid-burst: bit 0 at k+1, bit 1 at k+3, reset sampled at edge k+4.
        req(2'd0, 7'd0, 8'd10);
        chk("abort_bit0", STROBE, oh(0));
        tick();
        tick();
        chk("abort_bit1", STROBE, oh(1));
        tick();
        RESET = 1'b0;
        tick();
        chk("abort_strobe_cleared", STROBE, '0);
        chk("abort_ready_low", READY, 1'b0);
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("abort_no_done%0d", i), DONE, 1'b0);
            chk($sformatf("abort_no_strobe%0d", i), STROBE, '0);
            tick();
        end

        // Recovery after the aborted burst: channel 1 index 0 is bit 84.
        single("recover", 2'd1, 7'd0, 84, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
